// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : EX->MEM->WB/ID bus bundle for the memory stage | rev 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 212,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_ID_WD = 104,
  parameter int STALL_W      = 6
);

  logic [STALL_W-1:0]      stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_id_bus
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_id_bus
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : memory-access pipeline stage (load extract, WB select) | rev 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int EX_TO_MEM_WD = 212,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_ID_WD = 104,
  parameter int STALL_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int c_STALL_EXMEM = 3;
  localparam int c_STALL_MEMWB = 4;

  logic [EX_TO_MEM_WD-1:0] r_bus;
  logic                    r_first;
  logic [31:0]             r_rdata_buf;

  logic w_load_en;
  logic w_bubble;

  assign w_bubble  = bus.stall[c_STALL_EXMEM] & ~bus.stall[c_STALL_MEMWB];
  assign w_load_en = ~bus.stall[c_STALL_EXMEM];

  // The SRAM word is only valid in the cycle after the request; latch it so a
  // held stage keeps returning the original word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus       <= '0;
      r_first     <= 1'b0;
      r_rdata_buf <= '0;
    end else begin
      if (r_first) begin
        r_rdata_buf <= bus.data_sram_rdata;
      end
      if (w_bubble) begin
        r_bus   <= '0;
        r_first <= 1'b0;
      end else if (w_load_en) begin
        r_bus   <= bus.ex_to_mem_bus;
        r_first <= 1'b1;
      end else begin
        r_first <= 1'b0;
      end
    end
  end

  logic        w_inst_h;
  logic        w_inst_hu;
  logic        w_inst_b;
  logic        w_inst_bu;
  logic        w_hi_we;
  logic [31:0] w_hi_wdata;
  logic        w_lo_we;
  logic [31:0] w_lo_wdata;
  logic        w_r_lo;
  logic [31:0] w_r_lo_data;
  logic        w_r_hi;
  logic [31:0] w_r_hi_data;
  logic [31:0] w_ex_pc;
  logic        w_data_ram_en;
  logic [3:0]  w_data_ram_wen;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_ex_result;

  assign {w_inst_h, w_inst_hu, w_inst_b, w_inst_bu,
          w_hi_we, w_hi_wdata, w_lo_we, w_lo_wdata,
          w_r_lo, w_r_lo_data, w_r_hi, w_r_hi_data,
          w_ex_pc, w_data_ram_en, w_data_ram_wen, w_sel_rf_res,
          w_rf_we, w_rf_waddr, w_ex_result} = r_bus;

  logic [31:0] w_ld_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;

  assign w_ld_word = r_first ? bus.data_sram_rdata : r_rdata_buf;

  always_comb begin
    w_byte = w_ld_word[7:0];
    case (w_ex_result[1:0])
      2'd0:    w_byte = w_ld_word[7:0];
      2'd1:    w_byte = w_ld_word[15:8];
      2'd2:    w_byte = w_ld_word[23:16];
      default: w_byte = w_ld_word[31:24];
    endcase
  end

  // Halfword select uses only address bit 1; bit 0 is deliberately ignored.
  assign w_half = w_ex_result[1] ? w_ld_word[31:16] : w_ld_word[15:0];

  always_comb begin
    w_load_data = w_ld_word;
    if (w_inst_b) begin
      w_load_data = {{24{w_byte[7]}}, w_byte};
    end else if (w_inst_bu) begin
      w_load_data = {24'h0, w_byte};
    end else if (w_inst_h) begin
      w_load_data = {{16{w_half[15]}}, w_half};
    end else if (w_inst_hu) begin
      w_load_data = {16'h0, w_half};
    end
  end

  always_comb begin
    w_rf_wdata = w_ex_result;
    if (w_sel_rf_res) begin
      w_rf_wdata = w_load_data;
    end else if (w_r_hi) begin
      w_rf_wdata = w_r_hi_data;
    end else if (w_r_lo) begin
      w_rf_wdata = w_r_lo_data;
    end
  end

  assign bus.mem_to_wb_bus = {w_hi_we, w_hi_wdata, w_lo_we, w_lo_wdata,
                              w_ex_pc, w_rf_we, w_rf_waddr, w_rf_wdata};

  assign bus.mem_to_id_bus = {w_hi_we, w_hi_wdata, w_lo_we, w_lo_wdata,
                              w_rf_we, w_rf_waddr, w_rf_wdata};

  // Store strobes/enable belong to EX's SRAM request; only other stall bits
  // serve other stages.
  logic w_unused;
  assign w_unused = ^{bus.stall, w_data_ram_en, w_data_ram_wen};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage | rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [211:0] mk_bus(
    input logic [3:0] flags, input logic hi_we, input logic [31:0] hi_d,
    input logic lo_we, input logic [31:0] lo_d, input logic r_lo,
    input logic [31:0] r_lo_d, input logic r_hi, input logic [31:0] r_hi_d,
    input logic [31:0] pc, input logic ram_en, input logic [3:0] wen,
    input logic sel, input logic rf_we, input logic [4:0] waddr,
    input logic [31:0] res);
    return {flags, hi_we, hi_d, lo_we, lo_d, r_lo, r_lo_d, r_hi, r_hi_d,
            pc, ram_en, wen, sel, rf_we, waddr, res};
  endfunction

  function automatic logic [211:0] mk_ld(input logic [3:0] flags,
    input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] res);
    return mk_bus(flags, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                  pc, 1'b1, 4'h0, 1'b1, 1'b1, waddr, res);
  endfunction

  function automatic logic [135:0] mk_wb(input logic hi_we, input logic [31:0] hi_d,
    input logic lo_we, input logic [31:0] lo_d, input logic [31:0] pc,
    input logic rf_we, input logic [4:0] waddr, input logic [31:0] wd);
    return {hi_we, hi_d, lo_we, lo_d, pc, rf_we, waddr, wd};
  endfunction

  function automatic logic [103:0] mk_id(input logic hi_we, input logic [31:0] hi_d,
    input logic lo_we, input logic [31:0] lo_d, input logic rf_we,
    input logic [4:0] waddr, input logic [31:0] wd);
    return {hi_we, hi_d, lo_we, lo_d, rf_we, waddr, wd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifc.stall           = '0;
    ifc.ex_to_mem_bus   = mk_ld(4'b0000, 32'hBFC0_0000, 5'd1, 32'h100);
    ifc.data_sram_rdata = 32'hFFFF_FFFF;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== 136'h0) begin
      failures++;
      $display("FAIL reset_wb: got %h expected 0", ifc.mem_to_wb_bus);
    end
    checks++;
    if (ifc.mem_to_id_bus !== 104'h0) begin
      failures++;
      $display("FAIL reset_id: got %h expected 0", ifc.mem_to_id_bus);
    end
    tick();
    rst = 1'b1;
    ifc.ex_to_mem_bus = '0;
  endtask

  task automatic test_lw();
    tick();
    ifc.stall         = '0;
    ifc.ex_to_mem_bus = mk_ld(4'b0000, 32'h0000_1000, 5'd2, 32'h100);
    tick();
    ifc.data_sram_rdata = 32'hDEAD_BEEF;
    ifc.ex_to_mem_bus   = '0;
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_1000, 1'b1, 5'd2, 32'hDEAD_BEEF)) begin
      failures++;
      $display("FAIL lw_wb: got %h expected rf_wdata=deadbeef rf_we=1", ifc.mem_to_wb_bus);
    end
    checks++;
    if (ifc.mem_to_id_bus !== mk_id(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd2, 32'hDEAD_BEEF)) begin
      failures++;
      $display("FAIL lw_id: got %h expected rf_wdata=deadbeef", ifc.mem_to_id_bus);
    end
  endtask

  task automatic test_subword();
    logic [3:0]  flg [7];
    logic [31:0] adr [7];
    logic [31:0] exp [7];
    flg[0] = 4'b0010; adr[0] = 32'h103; exp[0] = 32'hFFFF_FF80; // lb
    flg[1] = 4'b0001; adr[1] = 32'h103; exp[1] = 32'h0000_0080; // lbu
    flg[2] = 4'b1000; adr[2] = 32'h102; exp[2] = 32'hFFFF_8011; // lh
    flg[3] = 4'b0100; adr[3] = 32'h102; exp[3] = 32'h0000_8011; // lhu
    flg[4] = 4'b0010; adr[4] = 32'h101; exp[4] = 32'h0000_0022; // lb positive
    flg[5] = 4'b1000; adr[5] = 32'h100; exp[5] = 32'h0000_2233; // lh low half
    flg[6] = 4'b1000; adr[6] = 32'h103; exp[6] = 32'hFFFF_8011; // lh, bit0 ignored
    for (int i = 0; i < 7; i++) begin
      tick();
      ifc.ex_to_mem_bus = mk_ld(flg[i], 32'h2000 + i, 5'(i + 8), adr[i]);
      tick();
      ifc.data_sram_rdata = 32'h8011_2233;
      ifc.ex_to_mem_bus   = '0;
      @(negedge clk);
      checks++;
      if (ifc.mem_to_wb_bus !== mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h2000 + i, 1'b1, 5'(i + 8), exp[i])) begin
        failures++;
        $display("FAIL subword_wb[%0d]: got %h expected rf_wdata=%h", i, ifc.mem_to_wb_bus, exp[i]);
      end
      checks++;
      if (ifc.mem_to_id_bus[31:0] !== exp[i]) begin
        failures++;
        $display("FAIL subword_id[%0d]: got %h expected %h", i, ifc.mem_to_id_bus[31:0], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    tick();
    ifc.ex_to_mem_bus = mk_ld(4'b0000, 32'h3000, 5'd11, 32'h200);
    tick();
    ifc.data_sram_rdata = 32'h1111_2222;
    ifc.ex_to_mem_bus   = mk_ld(4'b0001, 32'h3004, 5'd12, 32'h205);
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h3000, 1'b1, 5'd11, 32'h1111_2222)) begin
      failures++;
      $display("FAIL b2b_first: got %h expected rf_wdata=11112222", ifc.mem_to_wb_bus);
    end
    tick();
    ifc.data_sram_rdata = 32'h3344_5566;
    ifc.ex_to_mem_bus   = '0;
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h3004, 1'b1, 5'd12, 32'h0000_0055)) begin
      failures++;
      $display("FAIL b2b_second: got %h expected rf_wdata=00000055", ifc.mem_to_wb_bus);
    end
  endtask

  task automatic test_stall_hold();
    logic [135:0] exp_wb;
    exp_wb = mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h4000, 1'b1, 5'd13, 32'hCAFE_0001);
    tick();
    ifc.ex_to_mem_bus = mk_ld(4'b0000, 32'h4000, 5'd13, 32'h300);
    tick();
    ifc.data_sram_rdata = 32'hCAFE_0001;
    ifc.stall           = 6'b011000;
    ifc.ex_to_mem_bus   = mk_ld(4'b0000, 32'h4004, 5'd14, 32'h304);
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== exp_wb) begin
      failures++;
      $display("FAIL stall_cycle0: got %h expected %h", ifc.mem_to_wb_bus, exp_wb);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      ifc.data_sram_rdata = 32'h1234_5678 + i;
      @(negedge clk);
      checks++;
      if (ifc.mem_to_wb_bus !== exp_wb) begin
        failures++;
        $display("FAIL stall_cycle%0d: got %h expected %h", i, ifc.mem_to_wb_bus, exp_wb);
      end
      checks++;
      if (ifc.mem_to_id_bus[31:0] !== 32'hCAFE_0001) begin
        failures++;
        $display("FAIL stall_id%0d: got %h expected cafe0001", i, ifc.mem_to_id_bus[31:0]);
      end
    end
    tick();
    ifc.stall         = '0;
    ifc.ex_to_mem_bus = '0;
  endtask

  task automatic test_bubble();
    tick();
    ifc.ex_to_mem_bus = mk_bus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                               32'h5000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h1357_9BDF);
    tick();
    ifc.stall         = 6'b001000;
    ifc.ex_to_mem_bus = mk_ld(4'b0000, 32'h5004, 5'd8, 32'h400);
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h5000, 1'b1, 5'd7, 32'h1357_9BDF)) begin
      failures++;
      $display("FAIL alu_pass: got %h expected rf_wdata=13579bdf", ifc.mem_to_wb_bus);
    end
    tick();
    ifc.stall         = '0;
    ifc.ex_to_mem_bus = '0;
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== 136'h0) begin
      failures++;
      $display("FAIL bubble_wb: got %h expected 0", ifc.mem_to_wb_bus);
    end
    checks++;
    if (ifc.mem_to_id_bus !== 104'h0) begin
      failures++;
      $display("FAIL bubble_id: got %h expected 0", ifc.mem_to_id_bus);
    end
  endtask

  task automatic test_hilo_select();
    logic [211:0] vb [5];
    logic [31:0]  rd [5];
    logic [135:0] ew [5];
    logic [103:0] ei [5];
    vb[0] = mk_bus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D,
                   32'h6000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h1111_1111);
    rd[0] = 32'h9999_9999;
    ew[0] = mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h6000, 1'b1, 5'd4, 32'hCAFE_F00D);
    vb[1] = mk_bus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0BEE_F123, 1'b0, 32'h0,
                   32'h6004, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h2222_2222);
    rd[1] = 32'h9999_9999;
    ew[1] = mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h6004, 1'b1, 5'd6, 32'h0BEE_F123);
    vb[2] = mk_bus(4'b0000, 1'b1, 32'h8765_4321, 1'b1, 32'h0FED_CBA9, 1'b0, 32'h0, 1'b0, 32'h0,
                   32'h6008, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h3333_3333);
    rd[2] = 32'h9999_9999;
    ew[2] = mk_wb(1'b1, 32'h8765_4321, 1'b1, 32'h0FED_CBA9, 32'h6008, 1'b0, 5'd0, 32'h3333_3333);
    vb[3] = mk_bus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D,
                   32'h600C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h104);
    rd[3] = 32'h5555_AAAA;
    ew[3] = mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h600C, 1'b1, 5'd9, 32'h5555_AAAA);
    vb[4] = mk_bus(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                   32'h6010, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h108);
    rd[4] = 32'h7777_7777;
    ew[4] = mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h6010, 1'b0, 5'd0, 32'h108);
    for (int i = 0; i < 5; i++) begin
      ei[i] = {ew[i][135:70], ew[i][37:0]};
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      ifc.ex_to_mem_bus = vb[i];
      tick();
      ifc.data_sram_rdata = rd[i];
      ifc.ex_to_mem_bus   = '0;
      @(negedge clk);
      checks++;
      if (ifc.mem_to_wb_bus !== ew[i]) begin
        failures++;
        $display("FAIL hilo_wb[%0d]: got %h expected %h", i, ifc.mem_to_wb_bus, ew[i]);
      end
      checks++;
      if (ifc.mem_to_id_bus !== ei[i]) begin
        failures++;
        $display("FAIL hilo_id[%0d]: got %h expected %h", i, ifc.mem_to_id_bus, ei[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    ifc.ex_to_mem_bus = mk_ld(4'b0000, 32'h7000, 5'd9, 32'h200);
    tick();
    ifc.data_sram_rdata = 32'hA5A5_0001;
    ifc.stall           = 6'b011000;
    ifc.ex_to_mem_bus   = '0;
    tick();
    ifc.data_sram_rdata = 32'h0000_0BAD;
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus[31:0] !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL prereset_hold: got %h expected a5a50001", ifc.mem_to_wb_bus[31:0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ifc.mem_to_wb_bus !== 136'h0) begin
      failures++;
      $display("FAIL async_reset_wb: got %h expected 0", ifc.mem_to_wb_bus);
    end
    checks++;
    if (ifc.mem_to_id_bus !== 104'h0) begin
      failures++;
      $display("FAIL async_reset_id: got %h expected 0", ifc.mem_to_id_bus);
    end
    tick();
    tick();
    rst               = 1'b1;
    ifc.stall         = '0;
    ifc.ex_to_mem_bus = mk_ld(4'b0000, 32'h7100, 5'd3, 32'h104);
    tick();
    ifc.data_sram_rdata = 32'h0BAD_F00D;
    ifc.ex_to_mem_bus   = '0;
    @(negedge clk);
    checks++;
    if (ifc.mem_to_wb_bus !== mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h7100, 1'b1, 5'd3, 32'h0BAD_F00D)) begin
      failures++;
      $display("FAIL post_reset_lw: got %h expected rf_wdata=0badf00d", ifc.mem_to_wb_bus);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_lw();
    test_subword();
    test_back_to_back();
    test_stall_hold();
    test_bubble();
    test_hilo_select();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
